// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset defaults, NOP encoding, fetch FSM state encoding.
package cpu_pkg;

   localparam logic [15:0] NOP_ENC       = 16'h0000;
   localparam logic [15:0] RESET_PC_DEF  = 16'h0000;
   localparam logic [15:0] NOP_INSTR_DEF = NOP_ENC;
   localparam logic [15:0] PC_STEP       = 16'd2;

   typedef enum logic [1:0] {
      FS_REQ    = 2'd0,
      FS_WAIT   = 2'd1,
      FS_HALTED = 2'd2
   } fetch_state_t;

   // Instructions are halfword aligned, so branch targets drop bit 0.
   function automatic logic [15:0] align_pc(input logic [15:0] addr);
      return addr & 16'hFFFE;
   endfunction

endpackage

// File: rtl/cla_16bit.sv
// 16-bit carry-lookahead adder built from four 4-bit groups; the sum wraps modulo 2^16.
module cla_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum
);

   logic [15:0] p;
   logic [14:0] g;
   logic [15:0] c;
   logic [2:0]  gg;
   logic [2:0]  gp;
   logic [3:0]  cg;

   always_comb begin
      p  = a ^ b;
      g  = a[14:0] & b[14:0];
      gg = '0;
      gp = '0;
      cg = '0;
      c  = '0;
      cg[0] = cin;
      // Group carries for the lower three groups; the top group's carry-out is not needed.
      for (int k = 0; k < 3; k++) begin
         gp[k] = &p[4*k +: 4];
         gg[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         cg[k+1] = gg[k] | (gp[k] & cg[k]);
      end
      for (int k = 0; k < 4; k++) begin
         c[4*k] = cg[k];
         for (int j = 1; j < 4; j++) begin
            c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
         end
      end
   end

   assign sum = p ^ c;

endmodule

// File: rtl/fetch_skid_buf.sv
// One-entry {instruction, pc_plus2} holding buffer for returns that arrive while decode stalls.
module fetch_skid_buf (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  logic        flush,
   input  logic [15:0] instr_in,
   input  logic [15:0] pc2_in,
   output logic        full,
   output logic [15:0] instr,
   output logic [15:0] pc_plus2
);

   always_ff @(posedge clk) begin
      if (rst) begin
         full     <= 1'b0;
         instr    <= '0;
         pc_plus2 <= '0;
      end else if (flush) begin
         full <= 1'b0;
      end else if (push) begin
         full     <= 1'b1;
         instr    <= instr_in;
         pc_plus2 <= pc2_in;
      end else if (pop) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one read outstanding to imem and feeds decode.
// Handshakes: an imem request transfers at a posedge where imem_req && imem_ready; decode takes the output at a posedge where f_valid && !stall.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [15:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic         clk,
   input  logic         rst,
   output logic         imem_req,
   output logic [15:0]  imem_addr,
   input  logic         imem_ready,
   input  logic         imem_rvalid,
   input  logic [15:0]  imem_rdata,
   input  logic         stall,
   input  logic         redirect,
   input  logic [15:0]  redirect_pc,
   input  logic         halt,
   output logic [15:0]  instruction,
   output logic [15:0]  pc_plus2,
   output logic         f_valid,
   output logic         halted,
   output fetch_state_t dbg_state
);

   fetch_state_t state;
   logic [15:0]  pc;
   logic [15:0]  pc_inc;
   logic [15:0]  redirect_target;
   logic         drop;
   logic         skid_full;
   logic [15:0]  skid_instr;
   logic [15:0]  skid_pc2;
   logic         consume;
   logic         issue;
   logic         capture;
   logic         to_output;
   logic         skid_push;
   logic         skid_pop;
   logic         skid_flush;

   cla_16bit u_pc_inc (
      .a   (pc),
      .b   (PC_STEP),
      .cin (1'b0),
      .sum (pc_inc)
   );

   assign imem_req        = (state == FS_REQ) && !skid_full;
   assign imem_addr       = pc;
   assign dbg_state       = state;
   assign redirect_target = align_pc(redirect_pc);
   assign consume         = f_valid && !stall;
   assign issue           = imem_req && imem_ready;
   assign capture         = (state == FS_WAIT) && imem_rvalid && !drop && !redirect && !halt;
   // A request is only issued with the skid empty, so a capture never meets a full skid.
   assign to_output       = !f_valid || consume;
   assign skid_push       = capture && !to_output;
   assign skid_pop        = consume && skid_full && !redirect && !halt;
   assign skid_flush      = redirect || halt;

   fetch_skid_buf u_skid (
      .clk      (clk),
      .rst      (rst),
      .push     (skid_push),
      .pop      (skid_pop),
      .flush    (skid_flush),
      .instr_in (imem_rdata),
      .pc2_in   (pc_inc),
      .full     (skid_full),
      .instr    (skid_instr),
      .pc_plus2 (skid_pc2)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FS_REQ;
         pc          <= RESET_PC;
         drop        <= 1'b0;
         instruction <= NOP_INSTR;
         pc_plus2    <= RESET_PC + 16'd2;
         f_valid     <= 1'b0;
         halted      <= 1'b0;
      end else if (halt || state == FS_HALTED) begin
         state       <= FS_HALTED;
         halted      <= 1'b1;
         f_valid     <= 1'b0;
         instruction <= NOP_INSTR;
         drop        <= 1'b0;
      end else if (redirect) begin
         pc          <= redirect_target;
         f_valid     <= 1'b0;
         instruction <= NOP_INSTR;
         case (state)
            FS_REQ: begin
               // The old-address request still went out; its return must be thrown away.
               if (issue) begin
                  drop  <= 1'b1;
                  state <= FS_WAIT;
               end
            end
            FS_WAIT: begin
               if (imem_rvalid) begin
                  drop  <= 1'b0;
                  state <= FS_REQ;
               end else begin
                  drop <= 1'b1;
               end
            end
            default: ;
         endcase
      end else begin
         if (skid_pop) begin
            instruction <= skid_instr;
            pc_plus2    <= skid_pc2;
            f_valid     <= 1'b1;
         end else if (capture && to_output) begin
            instruction <= imem_rdata;
            pc_plus2    <= pc_inc;
            f_valid     <= 1'b1;
         end else if (consume) begin
            f_valid     <= 1'b0;
            instruction <= NOP_INSTR;
         end
         case (state)
            FS_REQ: begin
               if (issue) state <= FS_WAIT;
            end
            FS_WAIT: begin
               if (imem_rvalid) begin
                  state <= FS_REQ;
                  if (drop) drop <= 1'b0;
                  else      pc   <= pc_inc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory model, directed corner sequences,
// a redirect/wrap vector table and a randomized run against a sequential-stream reference.
module tb_fetch_stage;
   import cpu_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         imem_req;
   logic [15:0]  imem_addr;
   logic         imem_ready;
   logic         imem_rvalid;
   logic [15:0]  imem_rdata;
   logic         stall;
   logic         redirect;
   logic [15:0]  redirect_pc;
   logic         halt;
   logic [15:0]  instruction;
   logic [15:0]  pc_plus2;
   logic         f_valid;
   logic         halted;
   fetch_state_t dbg_state;

   fetch_stage dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .instruction (instruction),
      .pc_plus2    (pc_plus2),
      .f_valid     (f_valid),
      .halted      (halted),
      .dbg_state   (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- memory model ----------------
   logic [15:0] mem [0:255];
   int          lat;          // 0 selects a random latency of 1..4 per request
   bit          rdy_always;
   bit          busy;
   int          cnt;
   logic [15:0] paddr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      busy        = 1'b0;
      cnt         = 0;
      paddr       = '0;
      forever begin
         @(negedge clk);
         imem_rvalid = 1'b0;
         if (rst) begin
            busy       = 1'b0;
            imem_ready = 1'b0;
            continue;
         end
         if (busy) begin
            cnt--;
            if (cnt <= 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem[paddr[8:1]];
               busy        = 1'b0;
            end
         end
         if (imem_req) check("one_outstanding", {31'd0, busy}, 32'd0);
         imem_ready = !busy && (rdy_always || ($urandom_range(0, 1) == 1));
         if (imem_req && imem_ready) begin
            busy  = 1'b1;
            cnt   = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
            paddr = imem_addr;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not end, time %0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_fvalid(input string name, input int bound);
      int n;
      n = 0;
      while (!f_valid && n < bound) begin
         step();
         n++;
      end
      if (!f_valid) begin
         checks++;
         errors++;
         $display("FAIL %s: f_valid timeout after %0d cycles, required 1", name, bound);
      end
   endtask

   task automatic wait_rvalid(input string name, input int bound);
      int n;
      n = 0;
      while (!imem_rvalid && n < bound) begin
         step();
         n++;
      end
      if (!imem_rvalid) begin
         checks++;
         errors++;
         $display("FAIL %s: imem_rvalid timeout after %0d cycles, required 1", name, bound);
      end
   endtask

   task automatic wait_req_quiet(input string name, input int bound);
      int n;
      bit stale;
      n = 0;
      stale = 1'b0;
      while (!imem_req && n < bound) begin
         if (f_valid) stale = 1'b1;
         step();
         n++;
      end
      check({name, "_no_stale_valid"}, {31'd0, stale | f_valid}, 32'd0);
      check({name, "_req"}, {31'd0, imem_req}, 32'd1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [15:0] target;
      logic [15:0] data;
      logic [15:0] exp_instr;
      logic [15:0] exp_pc2;
      logic [15:0] exp_next;
   } vec_t;

   vec_t        vecs [4];
   logic [31:0] exp_q [$];

   initial begin
      logic [15:0] t;
      logic [15:0] mpc;
      logic [15:0] prev_instr;
      logic [15:0] prev_pc2;
      logic [31:0] exp_word;
      bit          hold_prev;
      bit          stall_v;
      bit          redir_v;
      int          n_deliv;

      vecs[0] = '{16'hFFFE, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      vecs[1] = '{16'h0041, 16'h7E57, 16'h7E57, 16'h0042, 16'h0042};
      vecs[2] = '{16'h1234, 16'hC0DE, 16'hC0DE, 16'h1236, 16'h1236};
      vecs[3] = '{16'h7FFF, 16'h9ABC, 16'h9ABC, 16'h8000, 16'h8000};

      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      mem[0]  = 16'hA123;
      mem[1]  = 16'hB456;
      mem[32] = 16'h3C40;

      rst         = 1'b1;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      halt        = 1'b0;
      lat         = 1;
      rdy_always  = 1'b1;
      step();
      step();

      // reset state
      check("rst_f_valid",   {31'd0, f_valid}, 32'd0);
      check("rst_instr",     {16'd0, instruction}, {16'd0, NOP_ENC});
      check("rst_pc_plus2",  {16'd0, pc_plus2}, 32'h0002);
      check("rst_halted",    {31'd0, halted}, 32'd0);
      check("rst_imem_req",  {31'd0, imem_req}, 32'd1);
      check("rst_imem_addr", {16'd0, imem_addr}, 32'h0000);
      rst = 1'b0;

      // first fetch, one-cycle memory latency
      wait_rvalid("t1_rvalid", 20);
      step();
      check("t1_f_valid",   {31'd0, f_valid}, 32'd1);
      check("t1_instr",     {16'd0, instruction}, 32'hA123);
      check("t1_pc_plus2",  {16'd0, pc_plus2}, 32'h0002);
      check("t1_next_req",  {31'd0, imem_req}, 32'd1);
      check("t1_next_addr", {16'd0, imem_addr}, 32'h0002);

      // stall for five cycles while the next return lands in the skid
      stall = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         check("t2_hold", {f_valid, instruction, pc_plus2[14:0]}, {1'b1, 16'hA123, 15'h0002});
         if (c >= 1) check("t2_no_req", {31'd0, imem_req}, 32'd0);
         if (c == 1) lat = 3;
      end
      stall = 1'b0;
      step();
      check("t2_skid_f_valid", {31'd0, f_valid}, 32'd1);
      check("t2_skid_instr",   {16'd0, instruction}, 32'hB456);
      check("t2_skid_pc2",     {16'd0, pc_plus2}, 32'h0004);
      check("t2_resume_req",   {31'd0, imem_req}, 32'd1);
      check("t2_resume_addr",  {16'd0, imem_addr}, 32'h0004);

      // redirect while a 3-cycle read is in flight
      step();
      check("t3_in_wait", {30'd0, dbg_state}, {30'd0, FS_WAIT});
      redirect    = 1'b1;
      redirect_pc = 16'h0040;
      step();
      redirect = 1'b0;
      wait_req_quiet("t3", 20);
      check("t3_addr", {16'd0, imem_addr}, 32'h0040);
      wait_fvalid("t3_fvalid", 20);
      check("t3_instr", {16'd0, instruction}, 32'h3C40);
      check("t3_pc2",   {16'd0, pc_plus2}, 32'h0042);

      // redirect in the same cycle as a return
      wait_rvalid("t4_rvalid", 20);
      redirect    = 1'b1;
      redirect_pc = 16'h0080;
      step();
      redirect = 1'b0;
      check("t4_f_valid", {31'd0, f_valid}, 32'd0);
      check("t4_instr",   {16'd0, instruction}, {16'd0, NOP_ENC});
      check("t4_req",     {31'd0, imem_req}, 32'd1);
      check("t4_addr",    {16'd0, imem_addr}, 32'h0080);

      // halt with a request outstanding
      step();
      check("t5_in_wait", {30'd0, dbg_state}, {30'd0, FS_WAIT});
      halt = 1'b1;
      step();
      halt = 1'b0;
      for (int c = 0; c < 20; c++) begin
         check("t5_halted_quiet", {29'd0, halted, f_valid, imem_req}, 32'h4);
         step();
      end
      rst = 1'b1;
      step();
      step();
      check("t5_rst_addr",   {16'd0, imem_addr}, 32'h0000);
      check("t5_rst_halted", {31'd0, halted}, 32'd0);
      rst = 1'b0;
      wait_fvalid("t5_fvalid", 20);
      check("t5_instr", {16'd0, instruction}, 32'hA123);
      check("t5_pc2",   {16'd0, pc_plus2}, 32'h0002);

      // redirect targets, alignment and wraparound
      for (int i = 0; i < 4; i++) begin
         t = vecs[i].target;
         mem[t[8:1]] = vecs[i].data;
         step();
         redirect    = 1'b1;
         redirect_pc = t;
         step();
         redirect = 1'b0;
         wait_fvalid("vec_fvalid", 20);
         check("vec_instr", {16'd0, instruction}, {16'd0, vecs[i].exp_instr});
         check("vec_pc2",   {16'd0, pc_plus2}, {16'd0, vecs[i].exp_pc2});
         check("vec_req",   {31'd0, imem_req}, 32'd1);
         check("vec_next",  {16'd0, imem_addr}, {16'd0, vecs[i].exp_next});
      end

      // randomized run: delivered stream must be the sequential instructions from the last target
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      rdy_always = 1'b0;
      lat        = 0;
      hold_prev  = 1'b0;
      prev_instr = '0;
      prev_pc2   = '0;
      mpc        = '0;
      n_deliv    = 0;
      exp_q.delete();
      step();
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if (hold_prev)
            check("rnd_hold", {f_valid, instruction, pc_plus2[14:0]}, {1'b1, prev_instr, prev_pc2[14:0]});
         if (hold_prev) check("rnd_hold_pc2_msb", {31'd0, pc_plus2[15]}, {31'd0, prev_pc2[15]});
         if (!f_valid) check("rnd_bubble_nop", {16'd0, instruction}, {16'd0, NOP_ENC});
         stall_v     = ($urandom_range(0, 3) == 0);
         redir_v     = (cyc == 0) || ($urandom_range(0, 29) == 0);
         stall       = stall_v;
         redirect    = redir_v;
         redirect_pc = 16'($urandom);
         if (redir_v) begin
            exp_q.delete();
            mpc = redirect_pc & 16'hFFFE;
         end else if (f_valid && !stall_v) begin
            while (exp_q.size() < 4) begin
               exp_q.push_back({mem[mpc[8:1]], 16'(mpc + 16'd2)});
               mpc = mpc + 16'd2;
            end
            exp_word = exp_q.pop_front();
            check("rnd_deliver", {instruction, pc_plus2}, exp_word);
            n_deliv++;
         end
         hold_prev  = f_valid && stall_v && !redir_v;
         prev_instr = instruction;
         prev_pc2   = pc_plus2;
         step();
      end
      stall    = 1'b0;
      redirect = 1'b0;
      check("rnd_liveness", {31'd0, n_deliv > 100}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
